// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard and forwarding controller for a 5-stage pipeline.
// Shadows EX/MEM destinations, registers EX operand selects, stalls on load-use.
//   state | meaning
//   RUN   | normal issue; a load-use hazard stalls ID and bubbles EX
//   STALL | bubble now sits in EX, so the held ID instruction issues next edge
module hazard_fwd_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    state_t             state_q, state_d;
    logic [REG_W-1:0]   ex_dest_q, mem_dest_q;
    logic               ex_we_q, ex_load_q, mem_we_q;
    logic [1:0]         fwd_a_q, fwd_b_q;
    logic [1:0]         fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               hz;

    // A WB-stage producer writes the regfile on the edge its consumer enters EX,
    // so it never needs a select and the shadow pipe stops at MEM.
    function automatic logic [1:0] fwd_sel(
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic             ex_we,
        input logic [REG_W-1:0] ex_dest,
        input logic             mem_we,
        input logic [REG_W-1:0] mem_dest
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!used || src == '0)
            sel = SEL_RF;
        else if (ex_we && ex_dest == src)
            sel = SEL_MEM;
        else if (mem_we && mem_dest == src)
            sel = SEL_WB;
        return sel;
    endfunction

    assign fwd_a_d = fwd_sel(id_rs_used, id_rs, ex_we_q, ex_dest_q, mem_we_q, mem_dest_q);
    assign fwd_b_d = fwd_sel(id_rt_used, id_rt, ex_we_q, ex_dest_q, mem_we_q, mem_dest_q);

    assign hz = ex_load_q && ex_we_q && (ex_dest_q != '0) &&
                ((id_rs_used && id_rs == ex_dest_q) || (id_rt_used && id_rt == ex_dest_q));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_flush) begin
                    bubble = 1'b1;
                end else if (hz) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = STALL;
                end
            end
            STALL: begin
                bubble  = ex_flush;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ex_dest_q  <= '0;
            ex_we_q    <= 1'b0;
            ex_load_q  <= 1'b0;
            mem_dest_q <= '0;
            mem_we_q   <= 1'b0;
            fwd_a_q    <= SEL_RF;
            fwd_b_q    <= SEL_RF;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_dest_q <= ex_dest_q;
            mem_we_q   <= ex_we_q;
            if (bubble) begin
                ex_dest_q <= '0;
                ex_we_q   <= 1'b0;
                ex_load_q <= 1'b0;
                fwd_a_q   <= SEL_RF;
                fwd_b_q   <= SEL_RF;
            end else begin
                ex_dest_q <= id_dest;
                ex_we_q   <= id_reg_write;
                ex_load_q <= id_mem_read;
                fwd_a_q   <= fwd_a_d;
                fwd_b_q   <= fwd_b_d;
            end
            if (stall && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: driver pushes expected outputs per cycle,
// a monitor pops and compares at the falling edge.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_rs_used, id_rt_used, id_reg_write, id_mem_read, ex_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, bubble;
    logic [1:0] stall_count;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_flush(ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble),
        .stall_count(stall_count)
    );

    typedef struct {
        string      nm;
        bit         chk;
        logic [1:0] fa, fb;
        logic       st, bu;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if ({fwd_a, fwd_b, stall, bubble, stall_count} !==
                        {e.fa, e.fb, e.st, e.bu, e.cnt}) begin
                        n_miss++;
                        $display("FAIL %s: got fa=%b fb=%b st=%b bu=%b cnt=%0d, want fa=%b fb=%b st=%b bu=%b cnt=%0d",
                                 e.nm, fwd_a, fwd_b, stall, bubble, stall_count,
                                 e.fa, e.fb, e.st, e.bu, e.cnt);
                    end
                end
            end
        end
    end

    // Apply one ID-stage vector for a cycle; expectations describe that same cycle:
    // fwd/cnt as registered at the previous edge, stall/bubble from these inputs.
    task automatic step(input logic r, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu,
                        input logic [4:0] dest, input logic we, input logic ld,
                        input logic fl, input bit chk, input string nm,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic bu, input logic [1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_dest = dest; id_reg_write = we; id_mem_read = ld; ex_flush = fl;
        e.nm = nm; e.chk = chk; e.fa = fa; e.fb = fb; e.st = st; e.bu = bu; e.cnt = cnt;
        sb.push_back(e);
    endtask

    initial begin
        int w;
        logic [1:0] c;
        rst = 1'b1; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
        id_dest = '0; id_reg_write = 0; id_mem_read = 0; ex_flush = 0;

        //   rst rs  u  rt  u  dst we ld fl  chk name             fa     fb     st bu cnt
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset",          2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 3, 1, 0, 0, 1, "t1_prod",        2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 3, 1, 7, 1, 6, 1, 0, 0, 1, "t1_cons_nostall",2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t1_ex_fwd",      2'b10, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 5, 1, 0, 0, 1, "t2_prod",        2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t2_gap",         2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 5, 0, 5, 1, 5, 1, 0, 0, 1, "t2_cons",        2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 5, 1, 0, 0, 1, "t2_mem_fwd",     2'b00, 2'b01, 0, 0, 2'd0);
        step(0, 5, 1, 5, 1, 0, 0, 0, 0, 1, "t2_cons2",       2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, "t2_youngest",    2'b10, 2'b10, 0, 0, 2'd0);
        step(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, "t4_r0_nostall",  2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t4_r0_fwd",      2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 4, 1, 1, 0, 1, "t3_lw",          2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 4, 1, 9, 1, 8, 1, 0, 0, 1, "t3_stall",       2'b00, 2'b00, 1, 1, 2'd0);
        step(0, 4, 1, 9, 1, 8, 1, 0, 0, 1, "t3_release",     2'b00, 2'b00, 0, 0, 2'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t3_wb_fwd",      2'b01, 2'b00, 0, 0, 2'd1);
        step(0, 0, 0, 0, 0, 4, 1, 1, 0, 1, "t5_lw",          2'b00, 2'b00, 0, 0, 2'd1);
        step(0, 4, 1, 0, 0, 8, 1, 0, 1, 1, "t5_flush",       2'b00, 2'b00, 0, 1, 2'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t5_after",       2'b00, 2'b00, 0, 0, 2'd1);

        // Four more load-use stalls push the 2-bit counter past its ceiling.
        for (int i = 0; i < 4; i++) begin
            c = (i + 1 >= 3) ? 2'd3 : 2'(i + 1);
            step(0, 0, 0, 0, 0, 4, 1, 1, 0, 0, "t6_lw",   2'b00, 2'b00, 0, 0, 2'd0);
            step(0, 4, 1, 9, 1, 8, 1, 0, 0, 1, "t6_stall", 2'b00, 2'b00, 1, 1, c);
            c = (i + 2 >= 3) ? 2'd3 : 2'(i + 2);
            step(0, 4, 1, 9, 1, 8, 1, 0, 0, 1, "t6_release", 2'b00, 2'b00, 0, 0, c);
        end

        step(0, 0, 0, 0, 0, 4, 1, 1, 0, 1, "t6_lw_sat",    2'b01, 2'b00, 0, 0, 2'd3);
        step(1, 4, 1, 9, 1, 8, 1, 0, 0, 1, "t6_rst_stall", 2'b00, 2'b00, 1, 1, 2'd3);
        step(0, 4, 1, 9, 1, 8, 1, 0, 0, 1, "t6_after_rst", 2'b00, 2'b00, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t6_idle",      2'b00, 2'b00, 0, 0, 2'd0);

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
